// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles UART bytes into header/opcode/address command
// frames and hands each completed command to the ICAPE2 sequencer.
// Optional feature: define UART_CMD_CHECKSUM_EN to require a trailing CHK byte
// (XOR of OP and the four address bytes). Without it the frame is 7 bytes.
//
// Handshake: cmd_valid/cmd_ready is a strict valid/ready pair. A transfer
// happens in any cycle where both are high. Once cmd_valid rises, it stays high
// and cmd_op/cmd_addr hold until that transfer. Only rst can withdraw cmd_valid
// early.
module uart_cmd_ctrl #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd50000,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_addr,
    input  logic        cmd_ready,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H1    = 3'd1,
        OPC   = 3'd2,
        ADDR  = 3'd3,
`ifdef UART_CMD_CHECKSUM_EN
        CHK   = 3'd4,
`endif
        ISSUE = 3'd5
    } state_t;

    state_t      state, state_n;
    logic [7:0]  op_q;
    logic [1:0]  byte_cnt;
    logic [31:0] tmo_cnt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [31:0] addr_q;
    logic [7:0]  xor_q;
`else
    // The last address byte goes straight from rx_data into cmd_addr, so only
    // the first three bytes need to be held here.
    logic [23:0] addr_q;
`endif

    logic       err_set;
    logic [1:0] err_val;
    logic       load_op;
    logic       shift_addr;
    logic       commit;
    logic       timed;
    logic       tmo_hit;

    assign cmd_valid = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_n    = state;
        err_set    = 1'b0;
        err_val    = 2'd0;
        load_op    = 1'b0;
        shift_addr = 1'b0;
        commit     = 1'b0;
        timed      = (state != IDLE) && (state != ISSUE);
        // A byte arriving in the expiry cycle takes priority over the timeout.
        tmo_hit    = timed && !rx_valid && (tmo_cnt == TIMEOUT_CYC - 32'd1);
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == HDR0) state_n = H1;
            end
            H1: begin
                if (rx_valid) begin
                    if (rx_data == HDR1)      state_n = OPC;
                    else if (rx_data == HDR0) state_n = H1;
                    else                      state_n = IDLE;
                end
            end
            OPC: begin
                if (rx_valid) begin
                    load_op = 1'b1;
                    if (rx_data == 8'h00) begin
                        err_set = 1'b1;
                        err_val = 2'd3;
                        state_n = IDLE;
                    end else begin
                        state_n = ADDR;
                    end
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    shift_addr = 1'b1;
                    if (byte_cnt == 2'd3) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_n = CHK;
`else
                        commit  = 1'b1;
                        state_n = ISSUE;
`endif
                    end
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == xor_q) begin
                        commit  = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        err_set = 1'b1;
                        err_val = 2'd2;
                        state_n = IDLE;
                    end
                end
            end
`endif
            ISSUE: begin
                // Bytes arriving while a command is pending are dropped.
                if (rx_valid) begin
                    err_set = 1'b1;
                    err_val = 2'd3;
                end
                if (cmd_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            err_set = 1'b1;
            err_val = 2'd1;
            state_n = IDLE;
        end
    end

    // Frame datapath: opcode/address capture, checksum, command and error regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 8'h00;
            addr_q    <= '0;
            byte_cnt  <= 2'd0;
            cmd_op    <= 8'h00;
            cmd_addr  <= 32'h0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
            xor_q     <= 8'h00;
`endif
        end else begin
            frame_err <= err_set;
            if (err_set) err_code <= err_val;
            if (load_op) begin
                op_q     <= rx_data;
                byte_cnt <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
                xor_q    <= rx_data;
`endif
            end
            if (shift_addr) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
                addr_q   <= {addr_q[23:0], rx_data};
                xor_q    <= xor_q ^ rx_data;
`else
                addr_q   <= {addr_q[15:0], rx_data};
`endif
            end
            // Outputs only change on a fully accepted frame.
            if (commit) begin
                cmd_op   <= op_q;
`ifdef UART_CMD_CHECKSUM_EN
                cmd_addr <= addr_q;
`else
                cmd_addr <= {addr_q, rx_data};
`endif
            end
        end
    end

    // Inter-byte timeout: runs only mid-frame, restarts on every byte.
    always_ff @(posedge clk) begin
        if (rst)                                      tmo_cnt <= 32'd0;
        else if (rx_valid || !timed || state_n == IDLE) tmo_cnt <= 32'd0;
        else                                          tmo_cnt <= tmo_cnt + 32'd1;
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed-vector bench for uart_cmd_ctrl with a short
// timeout so the expiry path is reached quickly.
module tb_uart_cmd_ctrl;

    localparam logic [31:0] TMO = 32'd64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic        cmd_ready = 1'b0;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    int          err_pulses = 0;
    int          valid_cycles = 0;
    int          acc_cnt = 0;
    logic [39:0] acc_cmd = '0;
    logic [39:0] exp_q[$];
    int          acc_seen = 0;

    uart_cmd_ctrl #(.TIMEOUT_CYC(TMO), .HDR0(8'h55), .HDR1(8'hAA)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_ready(cmd_ready), .frame_err(frame_err), .err_code(err_code),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Monitor: counts error pulses, valid cycles and accepted commands.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_pulses <= err_pulses + 1;
            if (cmd_valid) valid_cycles <= valid_cycles + 1;
            if (cmd_valid && cmd_ready) begin
                acc_cnt <= acc_cnt + 1;
                acc_cmd <= {cmd_op, cmd_addr};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    function automatic logic [7:0] chk_of(input logic [7:0] op, input logic [31:0] a);
        return op ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0];
    endfunction

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(op);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(chk_of(op, a));
`endif
    endtask

    // Wait (bounded) for the next handshake and compare against the queue head.
    task automatic expect_cmd(input logic [7:0] op, input logic [31:0] a);
        int n;
        logic [39:0] e;
        exp_q.push_back({op, a});
        n = 0;
        while (acc_cnt == acc_seen && n < 200) begin
            tick();
            n++;
        end
        chk("cmd_handshake", 64'(acc_cnt), 64'(acc_seen + 1));
        acc_seen = acc_cnt;
        e = exp_q.pop_front();
        chk("cmd_fields", 64'(acc_cmd), 64'(e));
    endtask

    initial begin
        int e0;
        int v0;
        int stable;

        // Reset state.
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_cmd_op", 64'(cmd_op), 64'h00);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'h0);

        // Basic frame with ready high: one-cycle valid.
        cmd_ready = 1'b1;
        e0 = err_pulses;
        v0 = valid_cycles;
        send_frame(8'h01, 32'h0000_1000);
        chk("t1_valid_next_cycle", 64'(cmd_valid), 64'd1);
        expect_cmd(8'h01, 32'h0000_1000);
        tick();
        tick();
        chk("t1_valid_one_cycle", 64'(valid_cycles - v0), 64'd1);
        chk("t1_no_err", 64'(err_pulses - e0), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Ready held low for 100 cycles with a stray byte mid-way.
        cmd_ready = 1'b0;
        send_frame(8'h01, 32'h0000_1000);
        e0 = err_pulses;
        stable = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) send_byte(8'h33);
            else         tick();
            if (cmd_valid && cmd_op == 8'h01 && cmd_addr == 32'h0000_1000) stable++;
        end
        chk("t2_stable_100", 64'(stable), 64'd100);
        tick();
        chk("t2_overrun_pulse", 64'(err_pulses - e0), 64'd1);
        chk("t2_overrun_code", 64'(err_code), 64'd3);
        cmd_ready = 1'b1;
        expect_cmd(8'h01, 32'h0000_1000);
        tick();
        chk("t2_idle", 64'(busy), 64'd0);

        // Noise in IDLE is discarded silently.
        e0 = err_pulses;
        send_byte(8'h12);
        send_byte(8'hAA);
        chk("noise_idle", 64'(busy), 64'd0);
        tick();
        chk("noise_no_err", 64'(err_pulses - e0), 64'd0);

        // Repeated HDR0, then a bad opcode.
        send_byte(8'h55);
        send_frame(8'h03, 32'h00AB_CDEF);
        expect_cmd(8'h03, 32'h00AB_CDEF);
        e0 = err_pulses;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h00);
        chk("badop_strobe", 64'(frame_err), 64'd1);
        tick();
        chk("badop_pulse", 64'(err_pulses - e0), 64'd1);
        chk("badop_code", 64'(err_code), 64'd3);
        chk("badop_idle", 64'(busy), 64'd0);
        chk("badop_op_kept", 64'(cmd_op), 64'h03);

        // Inter-byte timeout.
        e0 = err_pulses;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h01);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", 64'(frame_err), 64'd0);
        chk("tmo_still_busy", 64'(busy), 64'd1);
        tick();
        chk("tmo_strobe", 64'(frame_err), 64'd1);
        chk("tmo_code", 64'(err_code), 64'd1);
        chk("tmo_idle", 64'(busy), 64'd0);
        tick();
        chk("tmo_one_cycle", 64'(frame_err), 64'd0);
        chk("tmo_single_pulse", 64'(err_pulses - e0), 64'd1);
        send_frame(8'h05, 32'h1234_5678);
        expect_cmd(8'h05, 32'h1234_5678);

        // Byte landing in the expiry cycle beats the timeout.
        e0 = err_pulses;
        send_byte(8'h55);
        send_byte(8'hAA);
        repeat (TMO - 1) tick();
        send_byte(8'h06);
        chk("tmo_edge_no_err", 64'(frame_err), 64'd0);
        chk("tmo_edge_busy", 64'(busy), 64'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h46);
`endif
        expect_cmd(8'h06, 32'h0000_0040);
        tick();
        chk("tmo_edge_err_count", 64'(err_pulses - e0), 64'd0);

`ifdef UART_CMD_CHECKSUM_EN
        // Checksum mismatch.
        e0 = err_pulses;
        v0 = valid_cycles;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h02);
        repeat (4) send_byte(8'h00);
        send_byte(8'hFF);
        chk("chk_strobe", 64'(frame_err), 64'd1);
        chk("chk_code", 64'(err_code), 64'd2);
        tick();
        chk("chk_idle", 64'(busy), 64'd0);
        chk("chk_no_valid", 64'(valid_cycles - v0), 64'd0);
        chk("chk_pulse", 64'(err_pulses - e0), 64'd1);
`endif

        // Reset mid-frame.
        e0 = err_pulses;
        v0 = valid_cycles;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(cmd_valid), 64'd0);
        chk("mrst_err", 64'(frame_err), 64'd0);
        chk("mrst_err_code", 64'(err_code), 64'd0);
        tick();
        chk("mrst_no_pulse", 64'(err_pulses - e0), 64'd0);
        chk("mrst_no_valid_cycles", 64'(valid_cycles - v0), 64'd0);
        send_frame(8'h0A, 32'h0000_0004);
        expect_cmd(8'h0A, 32'h0000_0004);

        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32'd50000, SHALL set the inter-byte timeout in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter HDR0, default 8'h55, SHALL be the first frame header byte.
REQ-003 Parameter HDR1, default 8'hAA, SHALL be the second frame header byte.
REQ-004 clk  input  1  module clock, 50 MHz; all logic SHALL be single-clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx_data  input  8  received byte from the UART byte receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 cmd_valid  output  1  command available to the ICAPE2 sequencer.
REQ-009 cmd_op  output  8  command opcode.
REQ-010 cmd_addr  output  32  command address (warm-boot address for multiboot).
REQ-011 cmd_ready  input  1  sequencer accepts the command.
REQ-012 frame_err  output  1  one-cycle error strobe.
REQ-013 err_code  output  2  last error: 1 timeout, 2 checksum, 3 overrun/bad opcode; holds until the next error.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Frame format SHALL be: HDR0, HDR1, OP, A[31:24], A[23:16], A[15:8], A[7:0], plus CHK when checksum checking is enabled; CHK is the XOR of OP and the four address bytes.
REQ-016 The FSM SHALL have the states IDLE, H1, OPC, ADDR, CHK and ISSUE.
REQ-017 IDLE: rx_valid with HDR0 SHALL go to H1; any other byte SHALL be discarded silently.
REQ-018 H1 transitions SHALL be:
- HDR1 -> OPC.
- HDR0 -> stay in H1.
- Any other byte -> IDLE, with no frame_err.
REQ-019 OPC SHALL latch OP and seed the running XOR with OP.
- OP == 8'h00 -> frame_err with err_code 3, then IDLE.
- Otherwise -> ADDR.
REQ-020 ADDR SHALL shift bytes into the address register MSB-first using a 2-bit byte counter and XOR each byte into the running XOR.
- After the 4th byte -> CHK, or ISSUE if checksum checking is disabled.
REQ-021 CHK: CHK equal to the running XOR SHALL go to ISSUE; a mismatch SHALL pulse frame_err with err_code 2 and go to IDLE.
REQ-022 cmd_valid SHALL assert on the cycle after the rx_valid of the final frame byte.
REQ-023 While cmd_valid is high, cmd_op and cmd_addr SHALL remain stable.
REQ-024 cmd_valid SHALL deassert on the cycle after cmd_valid && cmd_ready, and the FSM SHALL return to IDLE.
REQ-025 rx_valid during ISSUE SHALL drop the byte and pulse frame_err with err_code 3; cmd_valid and the command SHALL be unaffected.
REQ-026 Timeout counter (32-bit) SHALL count in H1, OPC, ADDR and CHK, and SHALL clear on rx_valid and on entry to IDLE.
- On reaching TIMEOUT_CYC-1: pulse frame_err, set err_code 1, go to IDLE.
- If rx_valid arrives in that same cycle, the byte SHALL win and the timeout SHALL NOT fire.
REQ-027 The timeout SHALL NOT run in IDLE or ISSUE.
REQ-028 frame_err SHALL be exactly one cycle per error event.
REQ-029 cmd_op and cmd_addr SHALL update only from a completed frame and SHALL be unchanged by aborted frames.

Reset
REQ-030 On clk edge with rst high, the block SHALL take these values:
- FSM -> IDLE.
- cmd_valid, frame_err, busy -> 0.
- err_code -> 0; cmd_op -> 8'h00; cmd_addr -> 32'h0.
- Timeout counter, byte counter and XOR -> 0.
REQ-031 A reset asserted mid-frame or during ISSUE SHALL abandon the frame and drop cmd_valid on the next cycle, with no frame_err pulse.

Configuration
REQ-032 Macro UART_CMD_CHECKSUM_EN defined: the CHK byte SHALL be required and checked as in REQ-021; the frame is 8 bytes.
REQ-033 Macro UART_CMD_CHECKSUM_EN undefined: the CHK state and XOR logic SHALL be absent; the frame is 7 bytes and ADDR goes directly to ISSUE; err_code 2 SHALL never occur.

Verification
REQ-034 Stimulus 55 AA 01 00 00 10 00 plus CHK 11 (if enabled), cmd_ready held high.
- Required: cmd_valid for exactly 1 cycle, cmd_op = 01, cmd_addr = 32'h00001000, no frame_err.
REQ-035 Stimulus: same frame with cmd_ready low for 100 cycles.
- Required: cmd_valid and the fields stay stable for 100 cycles.
- A byte 33 sent meanwhile -> frame_err, err_code = 3, command unchanged.
REQ-036 Stimulus (CHK enabled): 55 AA 02 00 00 00 00 with CHK FF.
- Required: frame_err, err_code = 2, no cmd_valid, busy = 0 afterwards.
REQ-037 Stimulus: 55 AA 01, then idle for TIMEOUT_CYC cycles.
- Required: a single frame_err with err_code = 1.
- A following valid frame is accepted normally.
REQ-038 Stimulus: 55 55 AA 03 ...valid frame.
- Required: command accepted with cmd_op = 03.
- 55 AA 00 ... -> frame_err, err_code = 3.
REQ-039 Stimulus: rst pulsed after the 2nd address byte.
- Required: busy = 0, no frame_err, no cmd_valid; the next full frame decodes correctly.
